// File: rtl/dram_fifo_ctrl.sv
// FIFO controller around a dual-port dram: port A writes, port B reads, with a 2-entry FWFT output buffer.
// Optional `FIFO_AFULL_EN adds AF_LEVEL and a registered almost-full flag afull_o.
module dram_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned LVL_WIDTH  = ADDR_WIDTH + 2
`ifdef FIFO_AFULL_EN
  ,
  parameter int unsigned AF_LEVEL   = DEPTH
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic [LVL_WIDTH-1:0]  level_o,
  output logic                  empty_o,
`ifdef FIFO_AFULL_EN
  output logic                  afull_o,
`endif
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                  ram_rd_en_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d, obuf1_q, obuf1_d;
  logic [1:0]            obuf_cnt_q, obuf_cnt_d, obuf_cnt_pop;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [LVL_WIDTH-1:0]  level_q, level_d;
  logic                  empty_q, empty_d;
  logic                  push, pop, issue;
`ifdef FIFO_AFULL_EN
  logic                  afull_q, afull_d;
`endif

  // Next-state: handshakes, RAM read issue, output buffer shift/fill and status flags
  always_comb begin
    push         = s_valid_i & ready_q;
    pop          = valid_q & m_ready_i;
    // Slots already claimed in obuf (held + returning) must stay below 2 after this pop
    issue        = (ram_cnt_q != '0) &
                   ((3'(obuf_cnt_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
    wr_ptr_d     = push  ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d     = issue ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    ram_cnt_d    = ram_cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(issue);
    inflight_d   = issue;
    obuf0_d      = obuf0_q;
    obuf1_d      = obuf1_q;
    obuf_cnt_pop = obuf_cnt_q;
    if (pop) begin
      obuf0_d      = obuf1_q;
      obuf_cnt_pop = obuf_cnt_q - 2'd1;
    end
    obuf_cnt_d = obuf_cnt_pop;
    if (inflight_q) begin
      if (obuf_cnt_pop == 2'd0) obuf0_d = ram_rd_data_i;
      else                      obuf1_d = ram_rd_data_i;
      obuf_cnt_d = obuf_cnt_pop + 2'd1;
    end
    ready_d = (ram_cnt_d != CNT_WIDTH'(DEPTH));
    valid_d = (obuf_cnt_d != 2'd0);
    level_d = LVL_WIDTH'(ram_cnt_d) + LVL_WIDTH'(inflight_d) + LVL_WIDTH'(obuf_cnt_d);
    empty_d = (level_d == '0);
`ifdef FIFO_AFULL_EN
    afull_d = (level_d >= LVL_WIDTH'(AF_LEVEL));
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      obuf0_q    <= '0;
      obuf1_q    <= '0;
      obuf_cnt_q <= 2'd0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      level_q    <= '0;
      empty_q    <= 1'b1;
`ifdef FIFO_AFULL_EN
      afull_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      obuf0_q    <= obuf0_d;
      obuf1_q    <= obuf1_d;
      obuf_cnt_q <= obuf_cnt_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
`ifdef FIFO_AFULL_EN
      afull_q    <= afull_d;
`endif
    end
  end

  // RAM strobes follow the same-cycle handshake; stream outputs come straight from registers
  assign s_ready_o     = ready_q;
  assign m_valid_o     = valid_q;
  assign m_data_o      = obuf0_q;
  assign level_o       = level_q;
  assign empty_o       = empty_q;
`ifdef FIFO_AFULL_EN
  assign afull_o       = afull_q;
`endif
  assign ram_wr_en_o   = push;
  assign ram_wr_addr_o = wr_ptr_q;
  assign ram_wr_data_o = s_data_i;
  assign ram_rd_en_o   = issue;
  assign ram_rd_addr_o = rd_ptr_q;

endmodule

// File: doc/dram_fifo_ctrl.md
Name: dram_fifo_ctrl

Overview:
Single-clock FIFO controller that wraps the team's dual-port `dram`. It drives `dram` port A as the write port and port B as the read port, with both `dram` clocks tied to `clk_i` and WRITE_WIDTH = READ_WIDTH = DATA_WIDTH. It converts the fixed 1-cycle `dram` read latency into a first-word-fall-through valid/ready stream through a 2-entry output buffer, sustaining 1 beat/cycle. It sits directly upstream of the `dram` (driving its address and enables) and downstream of it (consuming its read data).

Parameters:
- DATA_WIDTH, 8, beat width; equals the `dram` WRITE_WIDTH and READ_WIDTH.
- DEPTH, 4, `dram` entries; power of 2, ≥2.
- ADDR_WIDTH, $clog2(DEPTH), RAM address width (derived; do not override).
- LVL_WIDTH, ADDR_WIDTH+2, width of `level_o` (derived).

Ports:
- clk_i  in  1  clock for the block and for both `dram` ports
- rst_i  in  1  asynchronous reset, active-high
- s_valid_i  in  1  push request
- s_ready_o  out  1  push accept
- s_data_i  in  DATA_WIDTH  push data
- m_valid_o  out  1  output beat valid
- m_ready_i  in  1  output beat accept
- m_data_o  out  DATA_WIDTH  output data (head of FIFO)
- level_o  out  LVL_WIDTH  total occupancy
- empty_o  out  1  level_o == 0
- ram_wr_en_o  out  1  to `dram` pa_wr_en_i
- ram_wr_addr_o  out  ADDR_WIDTH  to `dram` pa_addr_i
- ram_wr_data_o  out  DATA_WIDTH  to `dram` pa_wr_data_i
- ram_rd_en_o  out  1  to `dram` pb_rd_en_i
- ram_rd_addr_o  out  ADDR_WIDTH  to `dram` pb_addr_i
- ram_rd_data_i  in  DATA_WIDTH  from `dram` pb_rd_data_o; valid exactly 1 cycle after ram_rd_en_o

Behaviour:
- **State.** wr_ptr and rd_ptr (ADDR_WIDTH bits, wrap DEPTH-1→0). ram_cnt holds entries in the RAM not yet read (0..DEPTH). inflight is 1 bit. obuf is a 2-entry register FIFO with obuf_cnt 0..2.
- **Reset (rst_i=1, async).** Pointers, counters and inflight all go to 0. s_ready_o=0 while rst_i is high, then 1 from the first cycle after deassertion. m_valid_o=0, m_data_o=0, level_o=0, empty_o=1, ram_wr_en_o=0, ram_rd_en_o=0, addresses=0.
- **Reset mid-operation.** All contents are dropped. Read data returning in the cycle after reset is ignored.
- **Push.** push = s_valid_i & s_ready_o.
  - ram_wr_en_o = push; ram_wr_addr_o = wr_ptr; ram_wr_data_o = s_data_i (combinational).
  - On push, wr_ptr increments.
  - s_ready_o = (ram_cnt != DEPTH), derived only from registered state.
- **Read issue.** issue = (ram_cnt != 0) & (obuf_cnt + inflight − pop < 2), where pop = m_valid_o & m_ready_i.
  - ram_rd_en_o = issue; ram_rd_addr_o = rd_ptr.
  - On issue, rd_ptr increments and inflight_next = issue.
- **ram_cnt update.** ram_cnt_next = ram_cnt + push − issue. Same-cycle push and issue leave it unchanged. Write and read addresses never collide, because issue needs ram_cnt > 0 and push needs ram_cnt < DEPTH.
- **Return.** When inflight=1, ram_rd_data_i is written into the obuf tail on that edge.
- **Output.** m_valid_o = (obuf_cnt != 0); m_data_o = obuf head, registered. On pop the head advances. Return and pop in the same cycle are both honoured.
- **Occupancy.** level_o = ram_cnt + inflight + obuf_cnt. Maximum is DEPTH+2. empty_o = (level_o == 0).
- **Latency.** A beat accepted on edge E0 is presented with m_valid_o=1 after edge E2 when the FIFO was empty. Steady state is 1 beat/cycle in and out.
- **Boundaries.**
  - Pop while empty: no effect.
  - Push while s_ready_o=0: not accepted; s_data_i is ignored.
  - Data order is strictly preserved across pointer wrap.

Optional Feature:
FIFO_AFULL_EN
- **Defined:** adds parameter AF_LEVEL (default DEPTH) and output afull_o (1 bit, registered, reset 0). afull_o=1 when level_o ≥ AF_LEVEL, updated on the same edge as level_o.
- **Undefined:** no afull_o port and no AF_LEVEL parameter; all other behaviour is identical.

Test Plan:
- **Reset and single beat.** Reset, then push 0x5A one cycle → m_valid_o=1 with m_data_o=0x5A two edges later. level_o goes 1 then 0 after pop. empty_o returns to 1.
- **Fill with output stalled.** DEPTH=4, m_ready_i=0, push 0x00..0x09 continuously → exactly 6 beats accepted (0x00..0x05). s_ready_o=0 afterwards; level_o=6; ram_rd_en_o never asserted while obuf_cnt=2.
- **Drain.** From the full state, m_ready_i=1 → m_data_o sequence 0x00..0x05 on consecutive cycles. s_ready_o reasserts on the first pop cycle. Final level_o=0.
- **Streaming across wrap.** s_valid_i=1 and m_ready_i=1 for 100 cycles with an incrementing byte → every beat delivered in order at 1/cycle after 2-cycle latency. Pointers wrap 0..3 with no loss.
- **Random stress.** Random s_valid_i/m_ready_i (25–75%), 2000 cycles, scoreboard check → no loss, duplication or reordering. level_o always equals pushed − popped.
- **Mid-operation reset.** Assert rst_i with level_o=5 and a read in flight → next cycle level_o=0, m_valid_o=0, and the returned RAM data does not appear on m_data_o. With FIFO_AFULL_EN and AF_LEVEL=4, afull_o rises at level_o=4 and clears on reset.
